// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared types and constants for the redirect unit
package proc_pkg;

  localparam int          XLEN   = 32;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Higher encoding wins when several decode bits are set
  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_BNE  = 3'd1,
    CLS_BEQ  = 3'd2,
    CLS_JMP  = 3'd3,
    CLS_JR   = 3'd4
  } cls_t;

  function automatic cls_t pick_class(input logic jr, input logic j,
                                      input logic jal, input logic beq,
                                      input logic bne);
    if (jr)            return CLS_JR;
    else if (j || jal) return CLS_JMP;
    else if (beq)      return CLS_BEQ;
    else if (bne)      return CLS_BNE;
    else               return CLS_NONE;
  endfunction

endpackage

// File: rtl/proc_target_calc.sv
// rtl/proc_target_calc.sv - combinational target, taken and misalign resolution
module proc_target_calc
  import proc_pkg::*;
(
  input  logic [XLEN-1:0] i_ex_pc,
  input  logic            i_is_beq,
  input  logic            i_is_bne,
  input  logic            i_is_j,
  input  logic            i_is_jal,
  input  logic            i_is_jr,
  input  logic [15:0]     i_imm16,
  input  logic [25:0]     i_target26,
  input  logic [XLEN-1:0] i_rs_val,
  input  logic [XLEN-1:0] i_rt_val,
  output logic [XLEN-1:0] o_target,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic            o_taken,
  output logic            o_misalign,
  output logic            o_link
);

  cls_t            w_cls;
  logic [XLEN-1:0] w_br_off;

  assign w_cls      = pick_class(i_is_jr, i_is_j, i_is_jal, i_is_beq, i_is_bne);
  assign o_pc_plus4 = i_ex_pc + PC_INC;
  assign w_br_off   = {{14{i_imm16[15]}}, i_imm16, 2'b00};

  always_comb begin
    o_target   = '0;
    o_taken    = 1'b0;
    o_misalign = 1'b0;
    o_link     = 1'b0;
    case (w_cls)
      CLS_JR: begin
        o_target   = {i_rs_val[XLEN-1:2], 2'b00};
        o_taken    = 1'b1;
        o_misalign = |i_rs_val[1:0];
      end
      CLS_JMP: begin
        o_target = {o_pc_plus4[XLEN-1:28], i_target26, 2'b00};
        o_taken  = 1'b1;
        o_link   = i_is_jal;
      end
      CLS_BEQ: begin
        o_target = o_pc_plus4 + w_br_off;
        o_taken  = (i_rs_val == i_rt_val);
      end
      CLS_BNE: begin
        o_target = o_pc_plus4 + w_br_off;
        o_taken  = (i_rs_val != i_rt_val);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/proc_redirect.sv
// rtl/proc_redirect.sv - branch/jump resolution driving the PC redirect interface
module proc_redirect
  import proc_pkg::*;
#(
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic             is_beq,
  input  logic             is_bne,
  input  logic             is_j,
  input  logic             is_jal,
  input  logic             is_jr,
  input  logic [15:0]      imm16,
  input  logic [25:0]      target26,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  input  logic             stall,
  output logic [31:0]      new_pc,
  output logic             pc_src,
  output logic             flush,
  output logic             link_valid,
  output logic [31:0]      link_addr,
  output logic             misalign,
  output logic [CNT_W-1:0] taken_cnt
);

  // Flush cycles remaining after the acceptance cycle itself
  localparam logic [2:0] FCNT_INIT = 3'(FLUSH_DEPTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_fcnt;
  logic [31:0]      r_new_pc;
  logic             r_link_valid;
  logic [31:0]      r_link_addr;
  logic             r_misalign;
  logic [CNT_W-1:0] r_taken_cnt;

  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;
  logic        w_taken;
  logic        w_mis;
  logic        w_link;
  logic        w_resolve;
  logic        w_accept;

  proc_target_calc u_calc (
    .i_ex_pc    (ex_pc),
    .i_is_beq   (is_beq),
    .i_is_bne   (is_bne),
    .i_is_j     (is_j),
    .i_is_jal   (is_jal),
    .i_is_jr    (is_jr),
    .i_imm16    (imm16),
    .i_target26 (target26),
    .i_rs_val   (rs_val),
    .i_rt_val   (rt_val),
    .o_target   (w_target),
    .o_pc_plus4 (w_pc_plus4),
    .o_taken    (w_taken),
    .o_misalign (w_mis),
    .o_link     (w_link)
  );

  assign w_resolve = (r_state == IDLE) && ex_valid && w_taken;
  assign w_accept  = (r_state == HOLD) && !stall;

  always_ff @(posedge clk) begin
    if (nrst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_resolve) w_next = HOLD;
      HOLD:    if (!stall) w_next = (FLUSH_DEPTH > 1) ? FLUSH : IDLE;
      FLUSH:   if (r_fcnt <= 3'd1) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    pc_src = (r_state == HOLD);
    flush  = (r_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_fcnt       <= '0;
      r_new_pc     <= '0;
      r_link_valid <= 1'b0;
      r_link_addr  <= '0;
      r_misalign   <= 1'b0;
      r_taken_cnt  <= '0;
    end else begin
      r_link_valid <= w_resolve && w_link;
      if (w_resolve) r_new_pc <= w_target;
      if (w_resolve && w_link) r_link_addr <= w_pc_plus4;
      if (w_resolve && w_mis) r_misalign <= 1'b1;
      if (w_accept && (r_taken_cnt != {CNT_W{1'b1}}))
        r_taken_cnt <= r_taken_cnt + CNT_W'(1);
      if (w_accept)
        r_fcnt <= FCNT_INIT;
      else if (r_state == FLUSH)
        r_fcnt <= r_fcnt - 3'd1;
    end
  end

  assign new_pc     = r_new_pc;
  assign link_valid = r_link_valid;
  assign link_addr  = r_link_addr;
  assign misalign   = r_misalign;
  assign taken_cnt  = r_taken_cnt;

endmodule

// File: tb/tb_proc_redirect.sv
// tb/tb_proc_redirect.sv - directed self-checking bench for proc_redirect
module tb_proc_redirect;

  logic        clk;
  logic        nrst;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        is_beq, is_bne, is_j, is_jal, is_jr;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic [31:0] rs_val, rt_val;
  logic        stall;

  logic [31:0] new_pc, link_addr;
  logic        pc_src, flush, link_valid, misalign;
  logic [15:0] taken_cnt;

  logic [31:0] s_new_pc, s_link_addr;
  logic        s_pc_src, s_flush, s_link_valid, s_misalign;
  logic [1:0]  s_taken_cnt;

  int errors = 0;
  int checks = 0;

  proc_redirect dut (
    .clk(clk), .nrst(nrst), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .is_beq(is_beq), .is_bne(is_bne), .is_j(is_j), .is_jal(is_jal), .is_jr(is_jr),
    .imm16(imm16), .target26(target26), .rs_val(rs_val), .rt_val(rt_val),
    .stall(stall), .new_pc(new_pc), .pc_src(pc_src), .flush(flush),
    .link_valid(link_valid), .link_addr(link_addr), .misalign(misalign),
    .taken_cnt(taken_cnt)
  );

  proc_redirect #(.CNT_W(2)) dut_sat (
    .clk(clk), .nrst(nrst), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .is_beq(is_beq), .is_bne(is_bne), .is_j(is_j), .is_jal(is_jal), .is_jr(is_jr),
    .imm16(imm16), .target26(target26), .rs_val(rs_val), .rt_val(rt_val),
    .stall(stall), .new_pc(s_new_pc), .pc_src(s_pc_src), .flush(s_flush),
    .link_valid(s_link_valid), .link_addr(s_link_addr), .misalign(s_misalign),
    .taken_cnt(s_taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_pc = 0; is_beq = 0; is_bne = 0; is_j = 0; is_jal = 0; is_jr = 0;
    imm16 = 0; target26 = 0; rs_val = 0; rt_val = 0;
  endtask

  task automatic test_reset();
    clear_ex(); stall = 0; nrst = 1;
    tick(); tick();
    nrst = 0;
    checks++; if (pc_src !== 1'b0 || flush !== 1'b0) begin errors++;
      $display("FAIL reset_ctl got pc_src=%b flush=%b exp 0 0", pc_src, flush); end
    checks++; if (new_pc !== 32'h0 || link_addr !== 32'h0 || link_valid !== 1'b0) begin errors++;
      $display("FAIL reset_data got new_pc=%h link_addr=%h link_valid=%b exp 0", new_pc, link_addr, link_valid); end
    checks++; if (taken_cnt !== 16'h0 || misalign !== 1'b0 || s_taken_cnt !== 2'd0) begin errors++;
      $display("FAIL reset_cnt got cnt=%0d sat=%0d misalign=%b exp 0", taken_cnt, s_taken_cnt, misalign); end
  endtask

  task automatic test_no_valid();
    ex_valid = 0; is_j = 1; is_jr = 1; rs_val = 32'h44; target26 = 26'h10;
    tick();
    checks++; if (pc_src !== 1'b0 || flush !== 1'b0) begin errors++;
      $display("FAIL novalid got pc_src=%b flush=%b exp 0 0", pc_src, flush); end
    clear_ex();
  endtask

  task automatic test_beq();
    ex_valid = 1; is_beq = 1; ex_pc = 32'h100; rs_val = 5; rt_val = 5; imm16 = 16'h0003;
    tick();
    clear_ex();
    checks++; if (pc_src !== 1'b1 || flush !== 1'b1 || new_pc !== 32'h110) begin errors++;
      $display("FAIL beq_redirect got pc_src=%b flush=%b new_pc=%h exp 1 1 00000110", pc_src, flush, new_pc); end
    tick();
    checks++; if (pc_src !== 1'b0 || flush !== 1'b1 || taken_cnt !== 16'd1) begin errors++;
      $display("FAIL beq_accept got pc_src=%b flush=%b cnt=%0d exp 0 1 1", pc_src, flush, taken_cnt); end
    tick();
    checks++; if (flush !== 1'b0 || pc_src !== 1'b0) begin errors++;
      $display("FAIL beq_flush_end got flush=%b pc_src=%b exp 0 0", flush, pc_src); end
  endtask

  task automatic test_bne();
    ex_valid = 1; is_bne = 1; ex_pc = 32'h200; imm16 = 16'hFFFE; rs_val = 7; rt_val = 7;
    tick();
    checks++; if (pc_src !== 1'b0 || flush !== 1'b0) begin errors++;
      $display("FAIL bne_not_taken got pc_src=%b flush=%b exp 0 0", pc_src, flush); end
    rs_val = 1; rt_val = 2;
    tick();
    clear_ex();
    checks++; if (pc_src !== 1'b1 || new_pc !== 32'h1FC) begin errors++;
      $display("FAIL bne_taken got pc_src=%b new_pc=%h exp 1 000001fc", pc_src, new_pc); end
    tick(); tick();
    checks++; if (taken_cnt !== 16'd2 || flush !== 1'b0) begin errors++;
      $display("FAIL bne_done got cnt=%0d flush=%b exp 2 0", taken_cnt, flush); end
  endtask

  task automatic test_jal();
    ex_valid = 1; is_jal = 1; ex_pc = 32'h9000_0010; target26 = 26'h0000040;
    tick();
    clear_ex();
    checks++; if (pc_src !== 1'b1 || new_pc !== 32'h9000_0100) begin errors++;
      $display("FAIL jal_target got pc_src=%b new_pc=%h exp 1 90000100", pc_src, new_pc); end
    checks++; if (link_valid !== 1'b1 || link_addr !== 32'h9000_0014) begin errors++;
      $display("FAIL jal_link got link_valid=%b link_addr=%h exp 1 90000014", link_valid, link_addr); end
    tick();
    checks++; if (link_valid !== 1'b0) begin errors++;
      $display("FAIL jal_link_pulse got link_valid=%b exp 0", link_valid); end
    tick();
  endtask

  task automatic test_jr_hold();
    ex_valid = 1; is_jr = 1; rs_val = 32'h0000_1003; stall = 1;
    tick();
    is_jr = 0; is_beq = 1; ex_pc = 32'h100; rs_val = 5; rt_val = 5; imm16 = 16'h0003;
    checks++; if (pc_src !== 1'b1 || new_pc !== 32'h1000 || misalign !== 1'b1) begin errors++;
      $display("FAIL jr_resolve got pc_src=%b new_pc=%h misalign=%b exp 1 00001000 1", pc_src, new_pc, misalign); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc_src !== 1'b1 || flush !== 1'b1 || new_pc !== 32'h1000) begin errors++;
        $display("FAIL jr_hold%0d got pc_src=%b flush=%b new_pc=%h exp 1 1 00001000", i, pc_src, flush, new_pc); end
    end
    stall = 0;
    tick();
    checks++; if (pc_src !== 1'b0 || flush !== 1'b1 || taken_cnt !== 16'd4) begin errors++;
      $display("FAIL jr_accept got pc_src=%b flush=%b cnt=%0d exp 0 1 4", pc_src, flush, taken_cnt); end
    tick();
    clear_ex();
    checks++; if (flush !== 1'b0 || new_pc !== 32'h1000) begin errors++;
      $display("FAIL jr_flush_end got flush=%b new_pc=%h exp 0 00001000", flush, new_pc); end
    tick();
    checks++; if (pc_src !== 1'b0 || misalign !== 1'b1) begin errors++;
      $display("FAIL jr_ignored_beq got pc_src=%b misalign=%b exp 0 1", pc_src, misalign); end
  endtask

  task automatic test_priority();
    ex_valid = 1; is_jr = 1; is_j = 1; is_beq = 1; ex_pc = 32'h300;
    rs_val = 32'h400; rt_val = 32'h400; target26 = 26'h123; imm16 = 16'h0010;
    tick();
    clear_ex();
    checks++; if (pc_src !== 1'b1 || new_pc !== 32'h400) begin errors++;
      $display("FAIL priority got pc_src=%b new_pc=%h exp 1 00000400", pc_src, new_pc); end
    tick(); tick();
  endtask

  task automatic test_reset_in_hold();
    ex_valid = 1; is_j = 1; target26 = 26'h10; stall = 1;
    tick();
    clear_ex();
    checks++; if (pc_src !== 1'b1 || new_pc !== 32'h40) begin errors++;
      $display("FAIL rst_hold_pre got pc_src=%b new_pc=%h exp 1 00000040", pc_src, new_pc); end
    nrst = 1;
    tick();
    nrst = 0; stall = 0;
    checks++; if (pc_src !== 1'b0 || flush !== 1'b0 || taken_cnt !== 16'd0 || misalign !== 1'b0 || new_pc !== 32'h0) begin errors++;
      $display("FAIL rst_hold got pc_src=%b flush=%b cnt=%0d misalign=%b new_pc=%h exp all 0", pc_src, flush, taken_cnt, misalign, new_pc); end
    tick();
    checks++; if (pc_src !== 1'b0 || flush !== 1'b0) begin errors++;
      $display("FAIL rst_hold_idle got pc_src=%b flush=%b exp 0 0", pc_src, flush); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 5; i++) begin
      ex_valid = 1; is_j = 1; target26 = 26'h20;
      tick();
      clear_ex();
      tick(); tick();
    end
    checks++; if (s_taken_cnt !== 2'd3) begin errors++;
      $display("FAIL sat_cnt got %0d exp 3", s_taken_cnt); end
    checks++; if (taken_cnt !== 16'd5) begin errors++;
      $display("FAIL wide_cnt got %0d exp 5", taken_cnt); end
  endtask

  initial begin
    nrst = 1; stall = 0;
    clear_ex();
    test_reset();
    test_no_valid();
    test_beq();
    test_bne();
    test_jal();
    test_jr_hold();
    test_priority();
    test_reset_in_hold();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
